vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Replaces the combinational MPU/renderer VRAM mux in the top level with a clocked arbiter.
- It sits between the MPU bus decode and the Renderer on one side, and the external VRAM pins on the other.
- It grants one requester per access slot, drives the VRAM strobes for a fixed number of cycles, latches read data and returns an ack.
- During active display the renderer has priority. During blanking the MPU has priority. A wait counter prevents MPU starvation.

Parameters:
ADDR_WIDTH, 16, VRAM/request address width
DATA_WIDTH, 16, VRAM data width
ACCESS_CYCLES, 2, cycles the VRAM strobes stay asserted per access (min 1)
MPU_MAX_WAIT, 8, max cycles a pending MPU request may lose arbitration before it is forced to win

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
blank  in  1  hblank|vblank from DisplayController; 1 selects MPU priority
mpu_req  in  1  MPU access request; held until mpu_ack
mpu_wr  in  1  1=write, 0=read; stable while mpu_req
mpu_be  in  2  byte enables, active-high
mpu_addr  in  ADDR_WIDTH  MPU address
mpu_wdata  in  DATA_WIDTH  MPU write data
mpu_rdata  out  DATA_WIDTH  latched read data, valid with mpu_ack
mpu_ack  out  1  one-cycle completion pulse
ren_req  in  1  renderer read request; held until ren_ack
ren_addr  in  ADDR_WIDTH  renderer address
ren_rdata  out  DATA_WIDTH  latched read data, valid with ren_ack
ren_ack  out  1  one-cycle completion pulse
_vram_en  out  1  VRAM enable, active low
_vram_rd  out  1  VRAM read, active low
_vram_wr  out  1  VRAM write, active low
_vram_be  out  2  VRAM byte enable, active low
vram_addr  out  ADDR_WIDTH  VRAM address
vram_wdata  out  DATA_WIDTH  write data to pins
vram_oe  out  1  1 = top level drives vram_data from vram_wdata
vram_rdata  in  DATA_WIDTH  data sampled from pins

Behaviour:
- Reset values (async, immediate):
  - _vram_en, _vram_rd, _vram_wr = 1; _vram_be = 2'b11.
  - vram_addr = 0; vram_wdata = 0; vram_oe = 0.
  - mpu_ack = ren_ack = 0; mpu_rdata = ren_rdata = 0.
  - FSM = IDLE; wait counter = 0; slot counter = 0.
- FSM states: IDLE, ACCESS, TURN.
- IDLE:
  - No request: all strobes stay inactive.
  - Any request pending: pick a winner and go to ACCESS next cycle.
  - Register the winner's addr, be (renderer uses 2'b11), wr and wdata into the VRAM outputs.
- Winner selection, evaluated in IDLE:
  - Only one requester: it wins.
  - Both requesting and wait counter == MPU_MAX_WAIT: MPU wins.
  - Otherwise both requesting: blank=1 gives MPU, blank=0 gives renderer.
- ACCESS:
  - Strobes are asserted for exactly ACCESS_CYCLES cycles.
  - _vram_en = 0 throughout. _vram_rd = 0 for a read; _vram_wr = 0 for a write.
  - vram_oe = 1 only for an MPU write.
- End of access (last ACCESS cycle):
  - Read: vram_rdata is sampled on that clock edge into mpu_rdata or ren_rdata.
  - The winner's ack pulses high for exactly one cycle, the cycle after the last ACCESS cycle.
  - Strobes deassert in that same ack cycle.
- After ACCESS:
  - A write goes to TURN: one idle cycle with vram_oe = 0 to avoid bus contention. Then IDLE.
  - A read returns directly to IDLE.
- Latency:
  - Read, from request-to-IDLE edge to ack: 1 + ACCESS_CYCLES cycles.
  - Back-to-back reads: one access per ACCESS_CYCLES + 1 cycles.
- Wait counter:
  - Increments (saturating at MPU_MAX_WAIT) each time mpu_req is high in IDLE and the renderer wins.
  - Clears when the MPU wins or mpu_req is low.
- Requesters must hold req/addr/data until ack. Changes mid-access are ignored, because signals are captured in IDLE.
- A requester deasserting req before ack: the access still completes and the ack still pulses.
- A request arriving during ACCESS or TURN waits for IDLE. No request is lost.
- rdata registers hold their value until the next read for the same requester.
- Reset mid-access: strobes deassert immediately, no ack is issued, FSM = IDLE.
- ren_req is never treated as a write.

Decomposition:
- Shared package/header (vram_defs.vh): VRAM_ADDR_WIDTH, VRAM_DATA_WIDTH, state encodings ARB_IDLE, ARB_ACCESS, ARB_TURN, and requester IDs ARB_MPU, ARB_REN.
- One natural sub-module: vram_arb_priority, the combinational winner select (inputs: reqs, blank, wait_sat; output: grant).
- The top level keeps the tristate: vram_data = vram_oe ? vram_wdata : 'bz.

Test Plan:
1. Reset during ACCESS with ren_req=1 -> strobes all 1 in the same cycle, no ren_ack, next grant only after reset is released.
2. blank=0, ren_req=1 for addr 0x1234, vram_rdata=0xBEEF, ACCESS_CYCLES=2 -> _vram_en/_vram_rd low for 2 cycles with vram_addr=0x1234; ren_ack pulses 3 cycles after the request; ren_rdata=0xBEEF.
3. blank=1, mpu write addr 0x0040 data 0xA5A5 be=2'b01 -> _vram_wr low for 2 cycles, _vram_be=2'b10, vram_oe=1; mpu_ack pulses; one TURN cycle with vram_oe=0.
4. blank=1, mpu_req and ren_req raised together -> MPU served first, renderer served next; both acks seen, never in the same cycle.
5. blank=0, ren_req held continuously, mpu_req held -> renderer wins 8 times, then the MPU wins the 9th slot (MPU_MAX_WAIT=8); wait counter returns to 0.
6. MPU read immediately after an MPU write -> TURN cycle present; vram_oe never high while _vram_rd is low.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, FSM states and
// requester identifiers.
package vram_arbiter_pkg;
    localparam int VRAM_ADDR_WIDTH = 16;
    localparam int VRAM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_TURN   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_MPU = 1'b0,
        ARB_REN = 1'b1
    } arb_id_t;
endpackage

// File: rtl/vram_arb_priority.sv
// Combinational winner select between the MPU and the renderer for one VRAM
// access slot.
module vram_arb_priority
    import vram_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       blank,
    input  logic       wait_sat,
    output logic       grant_vld,
    output arb_id_t    grant
);

    always_comb begin
        grant_vld = |reqs;
        grant     = ARB_REN;
        // The MPU wins when alone, during blanking, or once it has waited too long.
        if (reqs[ARB_MPU] && (!reqs[ARB_REN] || wait_sat || blank))
            grant = ARB_MPU;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Clocked MPU/renderer VRAM arbiter: grants one requester per slot, drives the
// active-low VRAM strobes for ACCESS_CYCLES cycles, latches read data and acks.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH    = VRAM_DATA_WIDTH,
    parameter int ACCESS_CYCLES = 2,
    parameter int MPU_MAX_WAIT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blank,
    input  logic                  mpu_req,
    input  logic                  mpu_wr,
    input  logic [1:0]            mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    output logic                  mpu_ack,
    input  logic                  ren_req,
    input  logic [ADDR_WIDTH-1:0] ren_addr,
    output logic [DATA_WIDTH-1:0] ren_rdata,
    output logic                  ren_ack,
    output logic                  _vram_en,
    output logic                  _vram_rd,
    output logic                  _vram_wr,
    output logic [1:0]            _vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    output logic                  vram_oe,
    input  logic [DATA_WIDTH-1:0] vram_rdata
);

    localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MPU_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MPU_MAX_WAIT);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  slot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    arb_id_t           owner;
    logic              is_wr;
    logic              grant_vld;
    arb_id_t           grant;
    logic              grant_wr;
    logic              last_slot;

    vram_arb_priority u_priority (
        .reqs      ({ren_req, mpu_req}),
        .blank     (blank),
        .wait_sat  (wait_cnt == WAIT_MAX),
        .grant_vld (grant_vld),
        .grant     (grant)
    );

    // The renderer only ever reads.
    assign grant_wr  = (grant == ARB_MPU) && mpu_wr;
    assign last_slot = (slot_cnt == LAST_SLOT);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (grant_vld) state_nxt = ARB_ACCESS;
            ARB_ACCESS: if (last_slot) state_nxt = is_wr ? ARB_TURN : ARB_IDLE;
            ARB_TURN:   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            slot_cnt <= '0;
            wait_cnt <= '0;
            owner    <= ARB_MPU;
            is_wr    <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= (state == ARB_ACCESS && !last_slot) ? slot_cnt + 1'b1 : '0;
            if (state == ARB_IDLE && grant_vld) begin
                owner <= grant;
                is_wr <= grant_wr;
            end
            // Counts slots a pending MPU request lost to the renderer.
            if (!mpu_req)
                wait_cnt <= '0;
            else if (state == ARB_IDLE && grant_vld) begin
                if (grant == ARB_MPU)
                    wait_cnt <= '0;
                else if (wait_cnt != WAIT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            _vram_en   <= 1'b1;
            _vram_rd   <= 1'b1;
            _vram_wr   <= 1'b1;
            _vram_be   <= 2'b11;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_oe    <= 1'b0;
            mpu_ack    <= 1'b0;
            ren_ack    <= 1'b0;
            mpu_rdata  <= '0;
            ren_rdata  <= '0;
        end else begin
            mpu_ack <= 1'b0;
            ren_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_vld) begin
                        _vram_en  <= 1'b0;
                        _vram_rd  <= grant_wr;
                        _vram_wr  <= !grant_wr;
                        _vram_be  <= (grant == ARB_MPU) ? ~mpu_be : 2'b00;
                        vram_addr <= (grant == ARB_MPU) ? mpu_addr : ren_addr;
                        vram_oe   <= grant_wr;
                        if (grant_wr)
                            vram_wdata <= mpu_wdata;
                    end
                end
                ARB_ACCESS: begin
                    // Strobes drop and the ack rises on the same edge that samples read data.
                    if (last_slot) begin
                        _vram_en <= 1'b1;
                        _vram_rd <= 1'b1;
                        _vram_wr <= 1'b1;
                        _vram_be <= 2'b11;
                        vram_oe  <= 1'b0;
                        if (owner == ARB_MPU) begin
                            mpu_ack <= 1'b1;
                            if (!is_wr)
                                mpu_rdata <= vram_rdata;
                        end else begin
                            ren_ack <= 1'b1;
                            if (!is_wr)
                                ren_rdata <= vram_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
